// File: rtl/ooo_resp_pkg.sv
// Shared types and helpers for the out-of-order read responder: slot record,
// default parameter values, response data formation and the latency LFSR step.
package ooo_resp_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_ID_WIDTH   = 4;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_FIXED_LAT  = 2;
   localparam logic [3:0] DEF_LFSR_SEED = 4'h9;

   // Slot fields are sized for the widest supported ID/address; narrower
   // instances zero-extend on store.
   localparam int MAX_ID_W   = 16;
   localparam int MAX_ADDR_W = 32;
   localparam int CNT_W      = 4;

   typedef struct packed {
      logic                  valid;
      logic [MAX_ID_W-1:0]   id;
      logic [MAX_ADDR_W-1:0] addr;
      logic [CNT_W-1:0]      cnt;
   } slot_t;

   function automatic logic [MAX_ADDR_W-1:0] form_rdata(input logic [MAX_ADDR_W-1:0] addr,
                                                        input logic [MAX_ID_W-1:0]   id);
      return addr + MAX_ADDR_W'(id);
   endfunction

   // x^4 + x^3 + 1, period 15, never reaches zero from a nonzero seed
   function automatic logic [3:0] lfsr_next(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

endpackage

// File: rtl/ooo_resp_age_arb.sv
// Age matrix over the request slots plus oldest-eligible one-hot selection,
// where a ready slot is blocked by any older occupied slot with the same ID.
module ooo_resp_age_arb #(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DEPTH-1:0]            alloc_i,
   input  logic [DEPTH-1:0]            occ_i,
   input  logic [DEPTH-1:0]            ready_i,
   input  logic [DEPTH-1:0][DEPTH-1:0] same_id_i,
   output logic [DEPTH-1:0]            grant_o
);

   // older_q[j][i] set means slot j was allocated before slot i
   logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
   logic [DEPTH-1:0]            elig;

   always_comb begin
      older_d = older_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (alloc_i[k]) begin
            for (int j = 0; j < DEPTH; j++) begin
               older_d[k][j] = 1'b0;
               older_d[j][k] = (j != k);
            end
         end
      end
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      elig    = '0;
      grant_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         elig[i] = occ_i[i] & ready_i[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (occ_i[j] && older_q[j][i] && same_id_i[j][i]) elig[i] = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         grant_o[i] = elig[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (elig[j] && older_q[j][i]) grant_o[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the age matrix is control state and is cleared; stale rows are masked by occupancy anyway.
      if (rst) older_q <= '0;
      else     older_q <= older_d;
   end

endmodule

// File: rtl/ooo_read_responder.sv
// AXI-style read responder with DEPTH outstanding slots and out-of-order R return.
// Define OOO_RESP_LFSR_LATENCY_EN to draw per-request latency from a 4-bit LFSR.
module ooo_read_responder
   import ooo_resp_pkg::*;
#(
   parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int         ID_WIDTH   = DEF_ID_WIDTH,
   parameter int         DEPTH      = DEF_DEPTH,
   parameter int         FIXED_LAT  = DEF_FIXED_LAT,
   parameter logic [3:0] LFSR_SEED  = DEF_LFSR_SEED
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   s_arid_i,
   input  logic [ADDR_WIDTH-1:0] s_araddr_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [ID_WIDTH-1:0]   s_rid_o,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i
);

   slot_t                       slot_q [DEPTH];
   slot_t                       slot_d [DEPTH];
   logic [3:0]                  lfsr_q, lfsr_d;
   logic                        rvalid_q, rvalid_d;
   logic [ID_WIDTH-1:0]         rid_q, rid_d;
   logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;

   logic [DEPTH-1:0]            occ, ready, alloc_oh, grant;
   logic [DEPTH-1:0][DEPTH-1:0] same_id;
   logic                        ar_fire, r_load, found;
   logic [CNT_W-1:0]            lat;

   always_comb begin
      occ     = '0;
      ready   = '0;
      same_id = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ[i]   = slot_q[i].valid;
         ready[i] = slot_q[i].valid && (slot_q[i].cnt == '0);
         for (int j = 0; j < DEPTH; j++) same_id[j][i] = (slot_q[j].id == slot_q[i].id);
      end
   end

   assign s_arready_o = ~&occ;
   assign ar_fire     = s_arvalid_i & s_arready_o;

   always_comb begin
      alloc_oh = '0;
      found    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!occ[i] && !found) begin
            alloc_oh[i] = ar_fire;
            found       = 1'b1;
         end
      end
   end

`ifdef OOO_RESP_LFSR_LATENCY_EN
   assign lat = lfsr_q;
`else
   assign lat = CNT_W'(FIXED_LAT);
`endif
   assign lfsr_d = ar_fire ? lfsr_next(lfsr_q) : lfsr_q;

   ooo_resp_age_arb #(.DEPTH(DEPTH)) u_age_arb (
      .clk       (clk),
      .rst       (rst),
      .alloc_i   (alloc_oh),
      .occ_i     (occ),
      .ready_i   (ready),
      .same_id_i (same_id),
      .grant_o   (grant)
   );

   // The R register is a one-entry skid: it refills whenever it is empty or draining.
   assign r_load = (~rvalid_q | s_rready_i) & (|grant);

   always_comb begin
      slot_d   = slot_q;
      rvalid_d = rvalid_q;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      if (s_rready_i) rvalid_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_q[i].valid && slot_q[i].cnt != '0) slot_d[i].cnt = slot_q[i].cnt - CNT_W'(1);
         if (r_load && grant[i]) begin
            slot_d[i].valid = 1'b0;
            rvalid_d        = 1'b1;
            rid_d           = slot_q[i].id[ID_WIDTH-1:0];
            rdata_d         = DATA_WIDTH'(form_rdata(slot_q[i].addr, slot_q[i].id));
         end
         if (alloc_oh[i]) begin
            slot_d[i] = '{valid: 1'b1,
                          id:    MAX_ID_W'(s_arid_i),
                          addr:  MAX_ADDR_W'(s_araddr_i),
                          cnt:   lat};
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
         lfsr_q   <= LFSR_SEED;
         rvalid_q <= 1'b0;
         rid_q    <= '0;
         rdata_q  <= '0;
      end else begin
         slot_q   <= slot_d;
         lfsr_q   <= lfsr_d;
         rvalid_q <= rvalid_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign s_rvalid_o = rvalid_q;
   assign s_rid_o    = rid_q;
   assign s_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ooo_read_responder.sv
// Randomized self-checking bench for ooo_read_responder against a queue-based
// reference model; directed scenarios cover reset, full, ordering and mid-op reset.
module tb_ooo_read_responder;

   localparam int         DW        = 8;
   localparam int         AW        = 8;
   localparam int         IW        = 4;
   localparam int         DEPTH     = 4;
   localparam int         FIXED_LAT = 2;
   localparam logic [3:0] SEED      = 4'h9;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] s_arid_i;
   logic [AW-1:0] s_araddr_i;
   logic          s_arvalid_i;
   logic          s_arready_o;
   logic [DW-1:0] s_rdata_o;
   logic [IW-1:0] s_rid_o;
   logic          s_rvalid_o;
   logic          s_rready_i;

   ooo_read_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ID_WIDTH   (IW),
      .DEPTH      (DEPTH),
      .FIXED_LAT  (FIXED_LAT),
      .LFSR_SEED  (SEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_arid_i    (s_arid_i),
      .s_araddr_i  (s_araddr_i),
      .s_arvalid_i (s_arvalid_i),
      .s_arready_o (s_arready_o),
      .s_rdata_o   (s_rdata_o),
      .s_rid_o     (s_rid_o),
      .s_rvalid_o  (s_rvalid_o),
      .s_rready_i  (s_rready_i)
   );

   always #5 clk = ~clk;

   // Reference model: outstanding requests in acceptance order with remaining wait.
   typedef struct {
      int id;
      int addr;
      int rem;
   } req_t;

   req_t       mq[$];
   bit         m_rvalid;
   int         m_rid, m_rdata, m_last_lat;
   logic [3:0] m_lfsr;
   bit         m_acc;
   int         out_rid[$];
   int         out_data[$];
   int         n_checks = 0;
   int         n_errors = 0;
   bit         chk_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit arv, input int id, input int addr, input bit rr);
      int g;
      int lat;
      bit blocked;
      m_acc = 1'b0;
      if (r) begin
         mq.delete();
         m_rvalid = 1'b0;
         m_rid    = 0;
         m_rdata  = 0;
         m_lfsr   = SEED;
         return;
      end
      if (m_rvalid && rr) begin
         out_rid.push_back(m_rid);
         out_data.push_back(m_rdata);
      end
      m_acc = arv && (mq.size() < DEPTH);
      g = -1;
      if (!m_rvalid || rr) begin
         for (int k = 0; k < mq.size() && g < 0; k++) begin
            if (mq[k].rem == 0) begin
               blocked = 1'b0;
               for (int j = 0; j < k; j++) if (mq[j].id == mq[k].id) blocked = 1'b1;
               if (!blocked) g = k;
            end
         end
      end
      if (g >= 0) begin
         m_rvalid = 1'b1;
         m_rid    = mq[g].id;
         m_rdata  = (mq[g].addr + mq[g].id) % (1 << DW);
      end else if (rr) begin
         m_rvalid = 1'b0;
      end
      foreach (mq[k]) if (mq[k].rem > 0) mq[k].rem--;
      if (g >= 0) mq.delete(g);
      if (m_acc) begin
`ifdef OOO_RESP_LFSR_LATENCY_EN
         lat    = int'(m_lfsr);
         m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
`else
         lat = FIXED_LAT;
`endif
         m_last_lat = lat;
         mq.push_back('{id: id, addr: addr, rem: lat});
      end
   endtask

   // Called at a falling edge: drive inputs, compare, take one rising edge, return at next falling edge.
   task automatic cycle(input bit r, input bit arv, input int id, input int addr, input bit rr);
      rst         = r;
      s_arvalid_i = arv;
      s_arid_i    = id[IW-1:0];
      s_araddr_i  = addr[AW-1:0];
      s_rready_i  = rr;
      #1;
      if (chk_en) begin
         check("arready", s_arready_o, mq.size() < DEPTH);
         check("rvalid", s_rvalid_o, m_rvalid);
         check("rid", s_rid_o, m_rid);
         check("rdata", s_rdata_o, m_rdata);
      end
      @(posedge clk);
      model_edge(r, arv, id, addr, rr);
      @(negedge clk);
   endtask

   task automatic issue(input int id, input int addr, input bit rr);
      int tries = 0;
      do begin
         cycle(1'b0, 1'b1, id, addr, rr);
         tries++;
      end while (!m_acc && tries < 60);
      check("issue_timeout", tries >= 60, 1'b0);
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, rr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_cnt;
      int seen;
      int rv_cnt;
      int p23, p24;
      bit differs;

      rst = 1'b1; s_arvalid_i = 1'b0; s_arid_i = '0; s_araddr_i = '0; s_rready_i = 1'b0;
      @(negedge clk);
      cycle(1'b1, 1'b0, 0, 0, 1'b0);
      cycle(1'b1, 1'b0, 0, 0, 1'b0);
      chk_en = 1'b1;

      // Reset state
      check("rst_arready", s_arready_o, 1'b1);
      check("rst_rvalid", s_rvalid_o, 1'b0);
      check("rst_rid", s_rid_o, 0);
      check("rst_rdata", s_rdata_o, 0);

      // Single read: id=2 addr=0x10
      cycle(1'b0, 1'b1, 2, 'h10, 1'b1);
      lat_cnt = 0;
      while (!s_rvalid_o && lat_cnt < 40) begin
         cycle(1'b0, 1'b0, 0, 0, 1'b1);
         lat_cnt++;
      end
      check("single_lat", lat_cnt, m_last_lat + 1);
      check("single_rid", s_rid_o, 2);
      check("single_rdata", s_rdata_o, 'h12);
      idle(3, 1'b1);

      // Full: ids 1..5 with R stalled, a 6th AR held, then drain
      out_rid.delete(); out_data.delete();
      for (int i = 1; i <= 5; i++) issue(i, 'h30 + i, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 6, 'h40, 1'b0);
      check("full_arready", s_arready_o, 1'b0);
      check("full_rvalid_held", s_rvalid_o, 1'b1);
      idle(60, 1'b1);
      check("full_count", out_rid.size(), 5);
      for (int id = 1; id <= 5; id++) begin
         seen = 0;
         foreach (out_rid[k]) if (out_rid[k] == id) begin
            seen++;
            check("full_data", out_data[k], ('h30 + id + id) % 256);
         end
         check("full_once", seen, 1);
      end
`ifndef OOO_RESP_LFSR_LATENCY_EN
      foreach (out_rid[k]) check("full_order", out_rid[k], k + 1);
`endif

`ifdef OOO_RESP_LFSR_LATENCY_EN
      // Same-ID ordering
      out_rid.delete(); out_data.delete();
      issue(3, 'h20, 1'b1);
      issue(3, 'h21, 1'b1);
      idle(40, 1'b1);
      p23 = -1; p24 = -1;
      foreach (out_data[k]) begin
         if (out_data[k] == 'h23 && p23 < 0) p23 = k;
         if (out_data[k] == 'h24 && p24 < 0) p24 = k;
      end
      check("sameid_present", (p23 >= 0) && (p24 >= 0), 1'b1);
      check("sameid_order", p23 < p24, 1'b1);

      // Out-of-order return across distinct IDs
      out_rid.delete(); out_data.delete();
      for (int id = 2; id <= 6; id++) issue(id, 0, 1'b1);
      idle(60, 1'b1);
      check("ooo_count", out_rid.size(), 5);
      for (int id = 2; id <= 6; id++) begin
         seen = 0;
         foreach (out_rid[k]) if (out_rid[k] == id) seen++;
         check("ooo_once", seen, 1);
      end
      differs = 1'b0;
      foreach (out_rid[k]) begin
         check("ooo_data", out_data[k], out_rid[k]);
         if (out_rid[k] != k + 2) differs = 1'b1;
      end
      check("ooo_reordered", differs, 1'b1);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)), $urandom_range(0, 9) < 6);
      idle(60, 1'b1);

      // Mid-operation reset with three requests outstanding
      issue(7, 'h50, 1'b0);
      issue(8, 'h51, 1'b0);
      issue(9, 'h52, 1'b0);
      cycle(1'b1, 1'b0, 0, 0, 1'b0);
      rv_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 1'b0, 0, 0, 1'b1);
         if (s_rvalid_o) rv_cnt++;
      end
      check("midrst_no_rvalid", rv_cnt, 0);
      check("midrst_arready", s_arready_o, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ooo_read_responder.md
OOO_READ_RESPONDER -- requirements
Module: ooo_read_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning R data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning AR address width.
REQ-003 SHALL have parameter ID_WIDTH, default 4, meaning AR/R ID width.
REQ-004 SHALL have parameter DEPTH, default 4, meaning number of outstanding request slots.
REQ-005 SHALL have parameter FIXED_LAT, default 2, meaning per-request latency when the LFSR latency feature is off (range 0..15).
REQ-006 SHALL have parameter LFSR_SEED, default 4'h9, meaning the nonzero reset value of the latency LFSR.
REQ-007 SHALL have ports, one per line:
  clk  input  1  single clock; all logic on rising edge
  rst  input  1  synchronous, active-high reset
  s_arid_i  input  ID_WIDTH  request ID
  s_araddr_i  input  ADDR_WIDTH  request address
  s_arvalid_i  input  1  AR valid
  s_arready_o  output  1  AR ready
  s_rdata_o  output  DATA_WIDTH  response data
  s_rid_o  output  ID_WIDTH  response ID
  s_rvalid_o  output  1  R valid
  s_rready_i  input  1  R ready

Function
REQ-008 SHALL drive s_arready_o high iff at least one slot is free, from registered state only (no path from s_rready_i or s_arvalid_i).
REQ-009 SHALL, on AR handshake, allocate the lowest-index free slot, storing ID, address, latency counter L, and mark it youngest.
REQ-010 SHALL decrement each nonzero slot counter once per cycle; a slot with counter 0 is ready.
REQ-011 SHALL treat a ready slot as eligible only if no older occupied slot holds the same ID (AXI same-ID ordering).
REQ-012 SHALL select the oldest eligible slot; different-ID responses MAY leave out of order.
REQ-013 SHALL load the registered R output when s_rvalid_o is low or s_rready_i is high and an eligible slot exists, freeing that slot in the same edge.
REQ-014 SHALL set s_rdata_o = (zero-extended address + zero-extended ID) truncated to DATA_WIDTH (mod 2^DATA_WIDTH).
REQ-015 SHALL hold s_rvalid_o, s_rid_o, s_rdata_o stable while s_rvalid_o is high and s_rready_i is low.
REQ-016 SHALL, unobstructed, assert s_rvalid_o exactly L+1 cycles after the AR handshake edge (L=0 gives 1 cycle).
REQ-017 SHALL accept an AR and load R in the same cycle; a slot freed that cycle becomes allocatable next cycle.
REQ-018 SHALL back-to-back issue: with s_rready_i high and eligible slots, one response per cycle.
REQ-019 SHALL, when all DEPTH slots are full and output is stalled, hold s_arready_o low with no state loss.

Reset
REQ-020 SHALL, while rst is high at a clock edge, clear all slots, age state and counters, set s_rvalid_o=0, s_rid_o=0, s_rdata_o=0, s_arready_o=1 after the edge, LFSR=LFSR_SEED.
REQ-021 SHALL on reset mid-operation discard all outstanding requests and any pending R without emitting them.

Configuration
REQ-022 SHALL, with macro OOO_RESP_LFSR_LATENCY_EN defined, load L from a 4-bit maximal LFSR (x^4+x^3+1, advanced once per AR handshake), giving L in 1..15.
REQ-023 SHALL, without OOO_RESP_LFSR_LATENCY_EN, load L=FIXED_LAT for every request, making responses strictly in acceptance order.

Structure
REQ-024 SHALL place the slot struct (valid, id, addr, counter), default parameter constants and the data-formation function in package ooo_resp_pkg.
REQ-025 SHALL implement age tracking and oldest-eligible selection in one sub-module ooo_resp_age_arb (DEPTH x DEPTH age matrix, one-hot grant).

Verification
REQ-026 SHALL cover reset: rst high 2 cycles -> s_arready_o=1, s_rvalid_o=0, s_rid_o=0, s_rdata_o=0.
REQ-027 SHALL cover single read (macro off, FIXED_LAT=2): id=2 addr=0x10 -> s_rvalid_o 3 cycles later, rid=2, rdata=0x12.
REQ-028 SHALL cover full: 5 ARs ids 1..5 with s_rready_i=0 -> s_arready_o low after 4th accept, 5th held; raise s_rready_i -> rids 1,2,3,4 then 5, all data correct.
REQ-029 SHALL cover same-ID order (macro on): id=3 addr 0x20 then 0x21 -> rdata 0x23 strictly before 0x24.
REQ-030 SHALL cover out-of-order (macro on): ids 2,3,4,5,6 addr 0x00 -> each rid exactly once, rdata=id, order differing from issue order at seed 4'h9.
REQ-031 SHALL cover backpressure and mid-op reset: s_rready_i low 5 cycles -> outputs stable; rst pulse with 3 outstanding -> no further s_rvalid_o.
